// File: rtl/vram_pkg.sv
// Shared types and default widths for the VRAM arbiter slice.
package vram_pkg;

  localparam int VRAM_ADDR_W = 16;
  localparam int VRAM_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    RD_DATA,
    ACK
  } arb_state_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// Bundle of the video fetch port, the CPU bus port and the single-port RAM port.
interface vram_arbiter_if
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
);

  logic [ADDR_W-1:0] vid_addr;
  logic              vid_rd;
  logic [DATA_W-1:0] vid_data;

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // The arbiter is the slave of the video/CPU requesters and drives the RAM.
  modport slave (
    input  vid_addr, vid_rd, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    output vid_data, cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output vid_addr, vid_rd, cpu_req, cpu_we, cpu_addr, cpu_wdata, mem_rdata,
    input  vid_data, cpu_ack, cpu_rdata, mem_en, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/vram_wbuf.sv
// One-entry posted-write buffer used by vram_arbiter when VRAM_WBUF_EN is defined.
module vram_wbuf
  import vram_pkg::*;
#(
  parameter int ADDR_W = VRAM_ADDR_W,
  parameter int DATA_W = VRAM_DATA_W
) (
  input  logic              clk_pixel,
  input  logic              nreset,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              drain,
  output logic              full,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  // Load is only offered while empty and drain only while full, so they never collide.
  always_ff @(posedge clk_pixel or negedge nreset) begin
    if (!nreset) begin
      full <= 1'b0;
      addr <= '0;
      data <= '0;
    end else if (load) begin
      full <= 1'b1;
      addr <= load_addr;
      data <= load_data;
    end else if (drain) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/vram_arbiter.sv
// Video/CPU arbiter for a single-port synchronous VRAM; video always wins.
// Define VRAM_WBUF_EN to compile in the one-entry posted-write buffer.
module vram_arbiter
  import vram_pkg::*;
(
  input  logic           clk_pixel,
  input  logic           nreset,
  vram_arbiter_if.slave  bus
);

  arb_state_e state;
  arb_state_e state_nxt;
  logic       cpu_grant;

`ifdef VRAM_WBUF_EN
  logic                   wbuf_load;
  logic                   wbuf_drain;
  logic                   wbuf_full;
  logic [VRAM_ADDR_W-1:0] wbuf_addr;
  logic [VRAM_DATA_W-1:0] wbuf_data;

  assign wbuf_drain = wbuf_full && !bus.vid_rd;

  vram_wbuf #(
    .ADDR_W (VRAM_ADDR_W),
    .DATA_W (VRAM_DATA_W)
  ) u_wbuf (
    .clk_pixel (clk_pixel),
    .nreset    (nreset),
    .load      (wbuf_load),
    .load_addr (bus.cpu_addr),
    .load_data (bus.cpu_wdata),
    .drain     (wbuf_drain),
    .full      (wbuf_full),
    .addr      (wbuf_addr),
    .data      (wbuf_data)
  );
`endif

  assign bus.vid_data = bus.mem_rdata;

  always_ff @(posedge clk_pixel or negedge nreset) begin
    if (!nreset) begin
      state         <= IDLE;
      bus.cpu_rdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == RD_DATA) begin
        bus.cpu_rdata <= bus.mem_rdata;
      end
    end
  end

  // With the buffer, writes are posted regardless of video; reads wait for an empty buffer.
  always_comb begin
    state_nxt   = state;
    cpu_grant   = 1'b0;
    bus.cpu_ack = 1'b0;
`ifdef VRAM_WBUF_EN
    wbuf_load   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (bus.cpu_req) begin
`ifdef VRAM_WBUF_EN
          if (bus.cpu_we) begin
            if (!wbuf_full) begin
              wbuf_load = 1'b1;
              state_nxt = ACK;
            end
          end else if (!wbuf_full && !bus.vid_rd) begin
            cpu_grant = 1'b1;
            state_nxt = RD_DATA;
          end
`else
          if (!bus.vid_rd) begin
            cpu_grant = 1'b1;
            state_nxt = bus.cpu_we ? ACK : RD_DATA;
          end
`endif
        end
      end
      RD_DATA: state_nxt = ACK;
      ACK: begin
        bus.cpu_ack = 1'b1;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // RAM port mux: video, then buffer drain, then a direct CPU access; silent in reset.
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    if (!nreset) begin
      bus.mem_en = 1'b0;
    end else if (bus.vid_rd) begin
      bus.mem_en   = 1'b1;
      bus.mem_addr = bus.vid_addr;
`ifdef VRAM_WBUF_EN
    end else if (wbuf_drain) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = 1'b1;
      bus.mem_addr  = wbuf_addr;
      bus.mem_wdata = wbuf_data;
`endif
    end else if (cpu_grant) begin
      bus.mem_en    = 1'b1;
      bus.mem_we    = bus.cpu_we;
      bus.mem_addr  = bus.cpu_addr;
      bus.mem_wdata = bus.cpu_wdata;
    end
  end

endmodule
